// File: rtl/unidad_muldiv_pkg.sv
// unidad_muldiv_pkg: shared op codes, FSM encoding and constants for the muldiv unit
package unidad_muldiv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_MULH = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;
  localparam logic [31:0] SIGN_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} estado_t;
endpackage

// File: rtl/unidad_muldiv_paso.sv
// unidad_muldiv_paso: one iteration of shift-add multiply or restoring divide on a 2W accumulator
module unidad_muldiv_paso #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  input  logic           es_div,
  output logic [2*W-1:0] nxt
);
  logic [W:0] suma, hi, dif;
  logic ge;
  // divide: partial remainder needs W+1 bits once the next dividend bit is shifted in
  always_comb begin
    suma = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    hi = acc[2*W-1:W-1];
    dif = hi - {1'b0, opnd};
    ge = hi >= {1'b0, opnd};
    nxt = es_div ? {ge ? dif[W-1:0] : hi[W-1:0], acc[W-2:0], ge} : {suma, acc[W-1:1]};
  end
endmodule

// File: rtl/unidad_muldiv.sv
// unidad_muldiv: iterative RV32M multiply/divide unit driving the register file write port
module unidad_muldiv
  import unidad_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   info_a,
  input  logic [XLEN-1:0]   info_b,
  input  logic [REG_AW-1:0] add_dest_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              write_en,
  output logic [REG_AW-1:0] add_dest,
  output logic [XLEN-1:0]   write_data
);
  estado_t state;
  logic [2:0] op_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0] opnd, ma, mb, sres, v, res;
  logic [2*XLEN-1:0] acc, nxt, prod;
  logic [5:0] cnt;
  logic neg, a_s, b_s, sa, sb, z, ovf, neg_c;
  unidad_muldiv_paso #(.W(XLEN)) u_paso (.acc(acc), .opnd(opnd), .es_div(op_q[2]), .nxt(nxt));
  always_comb begin
    a_s = !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
    b_s = op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM;
    sa = a_s & info_a[XLEN-1];
    sb = b_s & info_b[XLEN-1];
    ma = sa ? -info_a : info_a;
    mb = sb ? -info_b : info_b;
    z = op[2] && info_b == '0;
    ovf = (op == OP_DIV || op == OP_REM) && info_a == SIGN_MIN && info_b == ALL_ONES;
    sres = z ? (op[1] ? info_a : ALL_ONES) : (op[1] ? '0 : SIGN_MIN);
    neg_c = (op[2] & op[1]) ? sa : sa ^ sb;
    prod = neg ? -acc : acc;
    v = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    res = op_q[2] ? (neg ? -v : v) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  // special cases preload the result in both halves and jump straight to the fix-up cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      write_en <= 1'b0;
      add_dest <= '0;
      write_data <= '0;
      op_q <= '0;
      rd_q <= '0;
      opnd <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
    end else begin
      done <= 1'b0;
      write_en <= 1'b0;
      case (state)
        ST_IDLE: if (start && !flush) begin
          state <= ST_CALC;
          busy <= 1'b1;
          op_q <= op;
          rd_q <= add_dest_in;
          opnd <= op[2] ? mb : ma;
          acc <= (z || ovf) ? {sres, sres} : {{XLEN{1'b0}}, op[2] ? ma : mb};
          cnt <= (z || ovf) ? 6'd32 : 6'd0;
          neg <= !(z || ovf) && neg_c;
        end
        ST_CALC: if (flush) begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end else if (!cnt[5]) begin
          acc <= nxt;
          cnt <= cnt + 6'd1;
        end else begin
          state <= ST_DONE;
          done <= 1'b1;
          write_en <= |rd_q;
          add_dest <= rd_q;
          write_data <= res;
        end
        default: begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_unidad_muldiv.sv
// tb_unidad_muldiv: directed vectors against an arithmetic reference model of unidad_muldiv
module tb_unidad_muldiv;
  logic clk = 1'b0;
  logic rst_n, start, flush;
  logic [2:0] op;
  logic [31:0] info_a, info_b, write_data;
  logic [4:0] add_dest_in, add_dest;
  logic busy, done, write_en;
  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;
  logic m_busy, m_done, m_we;
  logic [4:0] m_rd, m_rdq;
  logic [31:0] m_wd, m_res;
  int m_left;

  unidad_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .info_a(info_a), .info_b(info_b),
    .add_dest_in(add_dest_in), .flush(flush), .busy(busy), .done(done), .write_en(write_en),
    .add_dest(add_dest), .write_data(write_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p = '0;
    r = '0;
    case (o)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : 32'(ua % ub);
    endcase
    return r;
  endfunction

  function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // cycle-level expectation: countdown from accept to the single-cycle write pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_we <= 1'b0; m_rd <= '0; m_wd <= '0;
      m_rdq <= '0; m_res <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      m_we <= 1'b0;
      if (!m_busy) begin
        if (start && !flush) begin
          m_busy <= 1'b1;
          m_left <= is_special(op, info_a, info_b) ? 1 : 33;
          m_res <= ref_res(op, info_a, info_b);
          m_rdq <= add_dest_in;
        end
      end else if (m_left == 0) m_busy <= 1'b0;
      else if (flush) m_busy <= 1'b0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_we <= (m_rdq != 0);
          m_rd <= m_rdq;
          m_wd <= m_res;
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("cyc_busy", busy, m_busy);
    chk("cyc_done", done, m_done);
    chk("cyc_we", write_en, m_we);
    chk("cyc_rd", add_dest, m_rd);
    chk("cyc_wd", write_data, m_wd);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; op = o; info_a = a; info_b = b; add_dest_in = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (n < lim && !done) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n;
    issue(o, a, b, rd);
    wait_done(40, n);
    chk("latency", n, lat);
    chk("result", write_data, exp);
    chk("dest", add_dest, rd);
    chk("wen", write_en, rd != 0);
    chk("model_pin", ref_res(o, a, b), exp);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("idle_again", busy, 1'b0);
  endtask

  task automatic watch_quiet(input string nm);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | done | write_en;
    end
    chk(nm, seen, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
    info_a = '0; info_b = '0; add_dest_in = '0;
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wd", write_data, 32'h0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33);
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 33);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 33);
    run(3'd1, 32'h8000_0000, 32'h0001_0000, 5'd7, 32'hFFFF_8000, 33);
    run(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd8, 32'hFFFF_FFFA, 33);
    run(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd9, 32'hFFFF_FFFE, 33);
    run(3'd5, 32'd30, 32'd4, 5'd10, 32'd7, 33);
    run(3'd7, 32'd30, 32'd4, 5'd11, 32'd2, 33);
    run(3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, 32'd1, 33);
    run(3'd5, 32'd30, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    run(3'd6, 32'd30, 32'd0, 5'd14, 32'd30, 1);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 1);
    // second start mid-CALC must be ignored
    issue(3'd0, 32'd6, 32'd7, 5'd3);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'd5; info_a = 32'd100; info_b = 32'd7; add_dest_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, n);
    chk("repulse_lat", n, 23);
    chk("repulse_wd", write_data, 32'd42);
    chk("repulse_rd", add_dest, 5'd3);
    @(negedge clk);
    // asynchronous reset mid-CALC
    issue(3'd0, 32'd9, 32'd9, 5'd4);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_wd", write_data, 32'h0);
    chk("arst_rd", add_dest, 5'h0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("arst_quiet");
    // flush mid-CALC
    issue(3'd5, 32'd100, 32'd7, 5'd6);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    watch_quiet("flush_quiet");
    // flush beats start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; info_a = 32'd2; info_b = 32'd2; add_dest_in = 5'd1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", busy, 1'b0);
    run(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 33);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
